// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and types for the RAM port arbiter: access size encoding,
// FSM states, lane geometry and the alignment rule.
package ram_port_arbiter_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 16;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANE_W  = 8;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned OFS_W   = 2;
  localparam int unsigned SHIFT_W = 5;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_R = 2'b11;

  // RMW_READ names the grant cycle itself (read issued combinationally);
  // the register only ever holds IDLE or RMW_WRITE.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RMW_READ  = 2'd1,
    RMW_WRITE = 2'd2
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [OFS_W-1:0] ofs);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = ofs[0];
      SIZE_W:  bad = |ofs;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Core-side request/response bundle: fetch port plus load/store data port.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = ram_port_arbiter_pkg::DEFAULT_ADDR_W
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              if_rsp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [1:0]        d_req_size;
  logic              d_req_unsigned;
  logic [31:0]       d_req_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_rdata;
  logic              d_rsp_err;

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_unsigned, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_unsigned, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );
endinterface

// File: rtl/ram_port_arbiter_lane_unit.sv
// Combinational lane logic: little-endian load extract/extend and
// sub-word store merge into a RAM word.
module ram_lane_unit
  import ram_port_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [OFS_W-1:0]  ofs_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] merge_o
);
  logic [SHIFT_W-1:0] byte_sh;
  logic [SHIFT_W-1:0] half_sh;
  logic [LANE_W-1:0]  byte_v;
  logic [HALF_W-1:0]  half_v;

  always_comb begin
    byte_sh = {ofs_i, 3'b000};
    half_sh = {ofs_i[1], 4'b0000};
    byte_v  = LANE_W'(word_i >> byte_sh);
    half_v  = HALF_W'(word_i >> half_sh);
    rdata_o = '0;
    merge_o = word_i;
    case (size_i)
      SIZE_B: begin
        rdata_o = uns_i ? DATA_W'(byte_v) : {{(DATA_W-LANE_W){byte_v[LANE_W-1]}}, byte_v};
        merge_o = (word_i & ~(DATA_W'(32'hFF) << byte_sh))
                | (DATA_W'(wdata_i[LANE_W-1:0]) << byte_sh);
      end
      SIZE_H: begin
        rdata_o = uns_i ? DATA_W'(half_v) : {{(DATA_W-HALF_W){half_v[HALF_W-1]}}, half_v};
        merge_o = (word_i & ~(DATA_W'(32'hFFFF) << half_sh))
                | (DATA_W'(wdata_i[HALF_W-1:0]) << half_sh);
      end
      SIZE_W: begin
        rdata_o = word_i;
        merge_o = wdata_i;
      end
      default: begin
        rdata_o = '0;
        merge_o = word_i;
      end
    endcase
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and the data port,
// with RMW for sub-word stores and a starvation guard for fetch.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   core,
  output logic                ram_wren,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_write_data,
  input  logic [DATA_W-1:0]   ram_data
);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                if_pend_q, if_pend_d, if_err_q, if_err_d;
  logic                d_pend_q, d_pend_d, d_err_q, d_err_d, d_load_q, d_load_d;
  logic [OFS_W-1:0]    d_ofs_q, d_ofs_d;
  logic [1:0]          d_size_q, d_size_d;
  logic                d_uns_q, d_uns_d;
  logic [DATA_W-1:0]   d_st_q, d_st_d;

  logic                force_if, if_ready, d_ready, if_grant, d_grant, mis;
  logic [DATA_W-1:0]   lane_rdata, lane_merge;

  assign force_if = (starve_q == CNT_W'(STARVE_LIMIT));

  ram_lane_unit u_lane (
    .word_i  (ram_data),
    .ofs_i   (d_ofs_q),
    .size_i  (d_size_q),
    .uns_i   (d_uns_q),
    .wdata_i (d_st_q),
    .rdata_o (lane_rdata),
    .merge_o (lane_merge)
  );

  // Grant, RAM drive and next-state; RAM address/data are the next register values.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_pend_d = 1'b0;
    if_err_d  = if_err_q;
    d_pend_d  = 1'b0;
    d_err_d   = d_err_q;
    d_load_d  = d_load_q;
    d_ofs_d   = d_ofs_q;
    d_size_d  = d_size_q;
    d_uns_d   = d_uns_q;
    d_st_d    = d_st_q;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    if_grant  = 1'b0;
    d_grant   = 1'b0;
    ram_wren  = 1'b0;
    mis       = 1'b0;

    if (rst) begin
      state_d  = IDLE;
      starve_d = '0;
      addr_d   = '0;
      wdata_d  = '0;
      if_err_d = 1'b0;
      d_err_d  = 1'b0;
      d_load_d = 1'b0;
      d_ofs_d  = '0;
      d_size_d = '0;
      d_uns_d  = 1'b0;
      d_st_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          d_ready  = !(force_if && core.if_req_valid);
          if_ready = !core.d_req_valid || force_if;
          if_grant = core.if_req_valid && if_ready;
          d_grant  = core.d_req_valid && d_ready;
          if (if_grant) begin
            addr_d    = {core.if_req_addr[ADDR_W-1:2], 2'b00};
            if_pend_d = 1'b1;
            if_err_d  = |core.if_req_addr[1:0];
          end else if (d_grant) begin
            addr_d   = {core.d_req_addr[ADDR_W-1:2], 2'b00};
            mis      = misaligned(core.d_req_size, core.d_req_addr[1:0]);
            d_ofs_d  = core.d_req_addr[1:0];
            d_size_d = core.d_req_size;
            d_uns_d  = core.d_req_unsigned;
            d_st_d   = core.d_req_wdata;
            if (!mis && core.d_req_we && core.d_req_size != SIZE_W) begin
              state_d = RMW_WRITE;
            end else begin
              d_pend_d = 1'b1;
              d_err_d  = mis;
              d_load_d = !core.d_req_we;
              if (core.d_req_we && !mis) begin
                ram_wren = 1'b1;
                wdata_d  = core.d_req_wdata;
              end
            end
          end
        end
        RMW_WRITE: begin
          ram_wren = 1'b1;
          wdata_d  = lane_merge;
          d_pend_d = 1'b1;
          d_err_d  = 1'b0;
          d_load_d = 1'b0;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (!core.if_req_valid || if_grant) starve_d = '0;
      else if (d_grant && !force_if)      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    starve_q  <= starve_d;
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    if_pend_q <= if_pend_d;
    if_err_q  <= if_err_d;
    d_pend_q  <= d_pend_d;
    d_err_q   <= d_err_d;
    d_load_q  <= d_load_d;
    d_ofs_q   <= d_ofs_d;
    d_size_q  <= d_size_d;
    d_uns_q   <= d_uns_d;
    d_st_q    <= d_st_d;
  end

  assign ram_address    = addr_d;
  assign ram_write_data = wdata_d;

  // RAM read data lands the cycle after the grant, alongside the response pulse.
  assign core.if_req_ready = if_ready;
  assign core.d_req_ready  = d_ready;
  assign core.if_rsp_valid = if_pend_q;
  assign core.if_rsp_err   = if_pend_q && if_err_q;
  assign core.if_rsp_data  = (if_pend_q && !if_err_q) ? ram_data : '0;
  assign core.d_rsp_valid  = d_pend_q;
  assign core.d_rsp_err    = d_pend_q && d_err_q;
  assign core.d_rsp_rdata  = (d_pend_q && d_load_q && !d_err_q) ? lane_rdata : '0;

endmodule
